// File: rtl/normaliser_pipe_if.sv
// Stream bundle for the mantissa normaliser: input sample channel and normalised result channel.
// The master drives samples and result-ready; the slave (the normaliser) drives the rest.
interface normaliser_pipe_if #(
  parameter int WIDTH   = 50,
  parameter int EXP_W   = 11,
  parameter int SHIFT_W = $clog2(WIDTH)
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_mant;
  logic [EXP_W-1:0]   in_exp;
  logic               in_sig;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   out_mant;
  logic [EXP_W-1:0]   out_exp;
  logic [SHIFT_W-1:0] out_shift;
  logic               out_zero;
  logic               out_unf;

  modport master (
    output in_valid, in_mant, in_exp, in_sig, out_ready,
    input  in_ready, out_valid, out_mant, out_exp, out_shift, out_zero, out_unf
  );

  modport slave (
    input  in_valid, in_mant, in_exp, in_sig, out_ready,
    output in_ready, out_valid, out_mant, out_exp, out_shift, out_zero, out_unf
  );
endinterface

// File: rtl/normaliser_pipe.sv
// Two-stage valid/ready mantissa normaliser: S1 locates the leading significant bit,
// S2 clamps the shift against the exponent and left-shifts the mantissa.
module normaliser_pipe #(
  parameter int WIDTH   = 50,
  parameter int EXP_W   = 11,
  parameter int SHIFT_W = $clog2(WIDTH)
) (
  input logic              clk,
  input logic              rst,
  normaliser_pipe_if.slave bus
);
  localparam int CW = (EXP_W > SHIFT_W) ? EXP_W : SHIFT_W;

  function automatic logic [SHIFT_W-1:0] msb_index(input logic [WIDTH-1:0] v);
    msb_index = '0;
    for (int i = 0; i < WIDTH; i++)
      if (v[i]) msb_index = SHIFT_W'(i);
  endfunction

  logic s1_adv, s2_adv;

  logic               s1_valid_q;
  logic [WIDTH-1:0]   s1_mant_q;
  logic [EXP_W-1:0]   s1_exp_q;
  logic               s1_sig_q;
  logic [SHIFT_W-1:0] s1_p_q;
  logic               s1_zero_q;
  logic               s1_n2k_q;

  logic               s2_valid_q;
  logic [WIDTH-1:0]   s2_mant_q;
  logic [EXP_W-1:0]   s2_exp_q;
  logic [SHIFT_W-1:0] s2_shift_q;
  logic               s2_zero_q;
  logic               s2_unf_q;

  // Each stage loads when empty or when its content leaves this cycle.
  assign s2_adv       = ~s2_valid_q | bus.out_ready;
  assign s1_adv       = ~s1_valid_q | s2_adv;
  assign bus.in_ready = s1_adv;

  logic               neg;
  logic [WIDTH-1:0]   negated;
  logic [WIDTH-1:0]   lead_vec;
  logic [SHIFT_W-1:0] p_d;
  logic               zero_d;
  logic               n2k_d;

  // NOTE: every always_comb output gets a default first so no path leaves a latch behind.
  always_comb begin
    neg      = bus.in_sig & bus.in_mant[WIDTH-1];
    negated  = ~bus.in_mant + WIDTH'(1);
    lead_vec = neg ? ~bus.in_mant : bus.in_mant;
    zero_d   = (bus.in_mant == '0);
    // -2^k has a single set bit in its negation; that bit is the leading position k.
    n2k_d    = neg & ((negated & (negated - WIDTH'(1))) == '0);
    p_d      = n2k_d ? msb_index(negated) : msb_index(lead_vec);
  end

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  // NOTE: data registers are reset too, so the out_* ports read 0 while rst is high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_mant_q  <= '0;
      s1_exp_q   <= '0;
      s1_sig_q   <= 1'b0;
      s1_p_q     <= '0;
      s1_zero_q  <= 1'b0;
      s1_n2k_q   <= 1'b0;
    end else if (s1_adv) begin
      s1_valid_q <= bus.in_valid;
      if (bus.in_valid) begin
        s1_mant_q <= bus.in_mant;
        s1_exp_q  <= bus.in_exp;
        s1_sig_q  <= bus.in_sig;
        s1_p_q    <= p_d;
        s1_zero_q <= zero_d;
        s1_n2k_q  <= n2k_d;
      end
    end
  end

  logic [CW-1:0]      target;
  logic [SHIFT_W-1:0] shift_d;
  logic [EXP_W-1:0]   exp_d;
  logic               unf_d;
  logic [WIDTH-1:0]   mant_d;

  always_comb begin
    target  = '0;
    shift_d = '0;
    exp_d   = '0;
    unf_d   = 1'b0;
    if (!s1_sig_q)
      target = CW'(WIDTH-1) - CW'(s1_p_q);
    else if (!(s1_n2k_q && (s1_p_q == SHIFT_W'(WIDTH-1))))
      target = CW'(WIDTH-2) - CW'(s1_p_q);
    // -2^(WIDTH-1) is already canonical, so its target stays 0.
    if (!s1_zero_q) begin
      if (target <= CW'(s1_exp_q)) begin
        shift_d = SHIFT_W'(target);
        exp_d   = s1_exp_q - EXP_W'(target);
      end else begin
        shift_d = SHIFT_W'(s1_exp_q);
        unf_d   = 1'b1;
      end
    end
    mant_d = s1_mant_q << shift_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid_q <= 1'b0;
      s2_mant_q  <= '0;
      s2_exp_q   <= '0;
      s2_shift_q <= '0;
      s2_zero_q  <= 1'b0;
      s2_unf_q   <= 1'b0;
    end else if (s2_adv) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_mant_q  <= mant_d;
        s2_exp_q   <= exp_d;
        s2_shift_q <= shift_d;
        s2_zero_q  <= s1_zero_q;
        s2_unf_q   <= unf_d;
      end
    end
  end

  assign bus.out_valid = s2_valid_q;
  assign bus.out_mant  = s2_mant_q;
  assign bus.out_exp   = s2_exp_q;
  assign bus.out_shift = s2_shift_q;
  assign bus.out_zero  = s2_zero_q;
  assign bus.out_unf   = s2_unf_q;
endmodule

// File: tb/tb_normaliser_pipe.sv
// Scoreboard bench for normaliser_pipe (WIDTH=8, EXP_W=6): directed vectors with
// hand-computed results, backpressure stall and mid-stream reset.
module tb_normaliser_pipe;
  localparam int W = 8;
  localparam int E = 6;
  localparam int S = 3;

  typedef struct packed {
    logic [W-1:0] mant;
    logic [E-1:0] exp;
    logic [S-1:0] shift;
    logic         zero;
    logic         unf;
  } res_t;

  typedef struct packed {
    logic [W-1:0] mant;
    logic [E-1:0] exp;
    logic         sig;
    res_t         res;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  normaliser_pipe_if #(.WIDTH(W), .EXP_W(E), .SHIFT_W(S)) bus ();

  normaliser_pipe #(.WIDTH(W), .EXP_W(E), .SHIFT_W(S)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  localparam int NV = 14;
  vec_t vecs [NV];
  res_t exp_q [$];
  int   n_checks = 0;
  int   n_errors = 0;
  logic saw_in_ready_low = 1'b0;

  function automatic vec_t mk(input logic [W-1:0] m, input logic [E-1:0] e, input logic sg,
                              input logic [W-1:0] om, input logic [E-1:0] oe,
                              input logic [S-1:0] os, input logic oz, input logic ou);
    vec_t v;
    v.mant = m; v.exp = e; v.sig = sg;
    v.res.mant = om; v.res.exp = oe; v.res.shift = os; v.res.zero = oz; v.res.unf = ou;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Holds in_valid and data until the sample transfers; returns #1 after the transfer edge.
  task automatic send(input int idx);
    int waited = 0;
    bus.in_valid = 1'b1;
    bus.in_mant  = vecs[idx].mant;
    bus.in_exp   = vecs[idx].exp;
    bus.in_sig   = vecs[idx].sig;
    @(negedge clk);
    while (!bus.in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!bus.in_ready) begin
      check("send_timeout", {63'd0, bus.in_ready}, 64'd1);
      bus.in_valid = 1'b0;
    end else begin
      exp_q.push_back(vecs[idx].res);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 50) begin
      @(posedge clk);
      t++;
    end
    #1;
    check("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  // Monitor: pops the scoreboard on every output transfer and checks hold-stability on stalls.
  res_t cur, held, e;
  logic stall_prev = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      cur = '{bus.out_mant, bus.out_exp, bus.out_shift, bus.out_zero, bus.out_unf};
      if (!bus.in_ready) saw_in_ready_low = 1'b1;
      if (stall_prev) begin
        check("hold_valid", {63'd0, bus.out_valid}, 64'd1);
        check("hold_stable", 64'(cur), 64'(held));
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out", {63'd0, bus.out_valid}, 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("out_mant",  64'(cur.mant),  64'(e.mant));
          check("out_exp",   64'(cur.exp),   64'(e.exp));
          check("out_shift", 64'(cur.shift), 64'(e.shift));
          check("out_zero",  64'(cur.zero),  64'(e.zero));
          check("out_unf",   64'(cur.unf),   64'(e.unf));
        end
      end
      stall_prev = bus.out_valid && !bus.out_ready;
      held       = cur;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time %0t exceeded limit 100000", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    //              in_mant in_exp sig   out_mant out_exp shift zero unf
    vecs[0]  = mk(8'h16, 6'd10, 1'b0, 8'hB0, 6'd7,  3'd3, 1'b0, 1'b0);
    vecs[1]  = mk(8'hF4, 6'd10, 1'b1, 8'hA0, 6'd7,  3'd3, 1'b0, 1'b0);
    vecs[2]  = mk(8'hFC, 6'd10, 1'b1, 8'hC0, 6'd6,  3'd4, 1'b0, 1'b0);
    vecs[3]  = mk(8'hFF, 6'd10, 1'b1, 8'hC0, 6'd4,  3'd6, 1'b0, 1'b0);
    vecs[4]  = mk(8'h01, 6'd3,  1'b0, 8'h08, 6'd0,  3'd3, 1'b0, 1'b1);
    vecs[5]  = mk(8'h00, 6'd10, 1'b0, 8'h00, 6'd0,  3'd0, 1'b1, 1'b0);
    vecs[6]  = mk(8'h03, 6'd20, 1'b1, 8'h60, 6'd15, 3'd5, 1'b0, 1'b0);
    vecs[7]  = mk(8'h80, 6'd0,  1'b0, 8'h80, 6'd0,  3'd0, 1'b0, 1'b0);
    vecs[8]  = mk(8'h80, 6'd5,  1'b1, 8'h80, 6'd5,  3'd0, 1'b0, 1'b0);
    vecs[9]  = mk(8'h01, 6'd7,  1'b0, 8'h80, 6'd0,  3'd7, 1'b0, 1'b0);
    vecs[10] = mk(8'hE0, 6'd10, 1'b1, 8'hC0, 6'd9,  3'd1, 1'b0, 1'b0);
    vecs[11] = mk(8'hFF, 6'd2,  1'b1, 8'hFC, 6'd0,  3'd2, 1'b0, 1'b1);
    vecs[12] = mk(8'h00, 6'd5,  1'b1, 8'h00, 6'd0,  3'd0, 1'b1, 1'b0);
    vecs[13] = mk(8'h01, 6'd63, 1'b1, 8'h40, 6'd57, 3'd6, 1'b0, 1'b0);

    bus.in_valid  = 1'b0;
    bus.in_mant   = '0;
    bus.in_exp    = '0;
    bus.in_sig    = 1'b0;
    bus.out_ready = 1'b1;
    rst = 1'b0;
    #1 rst = 1'b1;
    #2;
    check("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
    check("rst_out_data",
          64'({bus.out_mant, bus.out_exp, bus.out_shift, bus.out_zero, bus.out_unf}), 64'd0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    @(posedge clk);
    #1;

    // Directed vectors, back-to-back, no backpressure.
    for (int i = 0; i < NV; i++) send(i);
    bus.in_valid = 1'b0;
    drain();

    // Backpressure: five samples, out_ready low for four cycles from the first out_valid.
    saw_in_ready_low = 1'b0;
    fork
      begin
        for (int i = 0; i < 5; i++) send(i);
        bus.in_valid = 1'b0;
      end
      begin
        int t = 0;
        @(posedge clk);
        #1;
        while (!bus.out_valid && t < 20) begin
          @(posedge clk);
          #1;
          t++;
        end
        bus.out_ready = 1'b0;
        repeat (4) @(posedge clk);
        #1 bus.out_ready = 1'b1;
      end
    join
    drain();
    check("in_ready_fell", {63'd0, saw_in_ready_low}, 64'd1);

    // Reset with two samples in flight, then one fresh sample.
    send(2);
    send(3);
    bus.in_valid = 1'b0;
    #1 rst = 1'b1;
    exp_q.delete();
    #1;
    check("rst_flush_valid", {63'd0, bus.out_valid}, 64'd0);
    check("rst_flush_data",
          64'({bus.out_mant, bus.out_exp, bus.out_shift, bus.out_zero, bus.out_unf}), 64'd0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    send(10);
    bus.in_valid = 1'b0;
    check("lat_cycle1_valid", {63'd0, bus.out_valid}, 64'd0);
    @(posedge clk);
    #1;
    check("lat_cycle2_valid", {63'd0, bus.out_valid}, 64'd1);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
